// File: rtl/core_dbg_itr_queue.sv
// core_dbg_itr_queue
// Debug register file with a multi-entry ITR (Instruction Transfer Register)
// queue. Debugger writes to ITR_ADDR are queued and handed to fetch through
// a valid/ready handshake. A STATUS register reports empty/full/overflow/count.
// The STATUS register also accepts overflow-clear and flush commands.
// Optional feature macro: CORE_DBG_ITR_COUNTER_EN. When defined, COUNT_ADDR
// reads a running count of popped instructions. Otherwise it reads as 0.

module core_dbg_itr_queue #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int ITR_DEPTH   = 4,
  parameter int ITR_ADDR    = 3,
  parameter int STATUS_ADDR = 4,
  parameter int COUNT_ADDR  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dbg_req,
  input  logic                  dbg_wr_rd,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_rd_ready,
  output logic                  itr_valid,
  input  logic                  itr_ready,
  output logic [DATA_WIDTH-1:0] itr_insn
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int PTR_W    = (ITR_DEPTH > 1) ? $clog2(ITR_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] ITR_A    = ADDR_WIDTH'(ITR_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STATUS_A = ADDR_WIDTH'(STATUS_ADDR);
  localparam logic [ADDR_WIDTH-1:0] COUNT_A  = ADDR_WIDTH'(COUNT_ADDR);
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(ITR_DEPTH - 1);
  localparam logic [7:0]            CNT_FULL = 8'(ITR_DEPTH);

  // Generic register storage and the queue itself
  logic [DATA_WIDTH-1:0] regs    [NUM_REGS];
  logic [DATA_WIDTH-1:0] itr_mem [ITR_DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [7:0]       count;
  logic             overflow;

  // Access decode
  logic wr_access;
  logic rd_access;
  logic itr_wr;
  logic status_wr;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic flush;
  logic clr_ovf;

  assign wr_access = dbg_req && dbg_wr_rd;
  assign rd_access = dbg_req && !dbg_wr_rd;
  assign itr_wr    = wr_access && (dbg_addr == ITR_A);
  assign status_wr = wr_access && (dbg_addr == STATUS_A);
  assign empty     = (count == 8'd0);
  assign full      = (count == CNT_FULL);
  assign pop       = itr_valid && itr_ready;
  // A pop in the same cycle frees a slot, so a push into a full queue still lands
  assign push      = itr_wr && (!full || pop);
  assign flush     = status_wr && dbg_wdata[3];
  assign clr_ovf   = status_wr && dbg_wdata[2];

  // Fetch side comes straight from registered state, never from itr_ready
  assign itr_valid = !empty;
  assign itr_insn  = itr_valid ? itr_mem[rd_ptr] : '0;

`ifdef CORE_DBG_ITR_COUNTER_EN
  logic [DATA_WIDTH-1:0] pop_count;

  // Pop counter: counts every fetch handshake, survives flush, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_count <= '0;
    end else if (pop) begin
      pop_count <= pop_count + DATA_WIDTH'(1);
    end
  end
`endif

  // Status word assembled from the current (pre-edge) queue state
  logic [DATA_WIDTH-1:0] status_word;
  always_comb begin
    status_word       = '0;
    status_word[0]    = empty;
    status_word[1]    = full;
    status_word[2]    = overflow;
    status_word[15:8] = count;
  end

  // Read data selection
  logic [DATA_WIDTH-1:0] rd_mux;
  always_comb begin
    rd_mux = regs[dbg_addr];
    if (dbg_addr == STATUS_A) begin
      rd_mux = status_word;
    end else if (dbg_addr == COUNT_A) begin
`ifdef CORE_DBG_ITR_COUNTER_EN
      rd_mux = pop_count;
`else
      rd_mux = '0;
`endif
    end
  end

  // Generic register writes and the registered one-cycle read response
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, regardless of statement order.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      dbg_rdata    <= '0;
      dbg_rd_ready <= 1'b0;
    end else begin
      if (wr_access && (dbg_addr != STATUS_A) && (dbg_addr != COUNT_A)) begin
        regs[dbg_addr] <= dbg_wdata;
      end
      dbg_rd_ready <= rd_access;
      if (rd_access) begin
        dbg_rdata <= rd_mux;
      end
    end
  end

  // Queue storage writes
  // NOTE: entry storage is deliberately not reset; count gates itr_valid and
  // itr_insn, so stale entries are never visible after reset or flush.
  always_ff @(posedge clk) begin
    if (push) begin
      itr_mem[wr_ptr] <= dbg_wdata;
    end
  end

  // Queue pointers, occupancy and sticky overflow; flush overrides a concurrent pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop) begin
          rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
        end
        if (push) begin
          wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + 8'd1;
        end else if (pop && !push) begin
          count <= count - 8'd1;
        end
      end

      if (clr_ovf) begin
        overflow <= 1'b0;
      end else if (itr_wr && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/core_dbg_itr_queue.md
# core_dbg_itr_queue

Parametrised debug register file with a multi-entry Instruction Transfer Register (ITR) queue. It sits between the core debug APB slave and the fetch stage. It stores generic debug registers and queues instructions written by the debugger to the ITR address. It presents them to fetch with a valid/ready handshake, so back-to-back debugger writes are no longer lost. It also reports queue status and overflow to the debugger.

## Interface
Parameters:
- ADDR_WIDTH, 5, debug register address width; register count NUM_REGS = 2**ADDR_WIDTH
- DATA_WIDTH, 32, debug register and instruction width
- ITR_DEPTH, 4, ITR queue entries; any value from 1 to 255
- ITR_ADDR, 3, write address that pushes the ITR queue
- STATUS_ADDR, 4, status/control register address
- COUNT_ADDR, 5, popped-instruction counter address

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- dbg_req  in  1  debug access request, one-cycle pulse per access
- dbg_wr_rd  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_WIDTH  register address
- dbg_wdata  in  DATA_WIDTH  write data
- dbg_rdata  out  DATA_WIDTH  read data, registered
- dbg_rd_ready  out  1  read data valid, one-cycle pulse
- itr_valid  out  1  queue head valid toward fetch
- itr_ready  in  1  fetch accepts head
- itr_insn  out  DATA_WIDTH  queue head instruction

## Operation
- **Generic registers (write).** A write to any address other than STATUS_ADDR or COUNT_ADDR stores dbg_wdata in reg[addr].
- **Generic registers (read).** A read returns reg[addr].
- **ITR write.** A write to ITR_ADDR also stores the value, so a read of ITR_ADDR returns the last value written. If the queue is not full, the write pushes dbg_wdata into the queue.
- **ITR write when full.** The write is dropped and the sticky overflow bit is set. The exception is a pop in the same cycle: the pop frees an entry, so the push is accepted and the count is unchanged.
- **Pop.** A pop occurs when itr_valid && itr_ready at a clock edge. The head advances and the count decrements.
- **Fetch outputs.** itr_valid = (count != 0). itr_insn is the head entry. Both come from registered state only; there is no combinational path from itr_ready.
- **STATUS read:**
  - bit0 = empty
  - bit1 = full
  - bit2 = overflow (sticky)
  - bits[15:8] = count
  - all other bits = 0
- **STATUS write:**
  - bit2 = 1 clears overflow
  - bit3 = 1 flushes the queue (count becomes 0, pointers reset)
  - other bits ignored
  - no storage
- **Flush priority.** Flush in the same cycle as a pop: flush wins, and the count becomes 0.
- **COUNT_ADDR.** See Configuration. Writes to COUNT_ADDR are ignored.
- **Pointers and count.** Read/write pointers wrap modulo ITR_DEPTH; ITR_DEPTH is not required to be a power of two. The count width is 8 bits.
- **Read with no request.** When dbg_req = 0, dbg_rd_ready = 0 and dbg_rdata holds its previous value.

## Timing
- **Reset values.** All outputs 0: dbg_rdata, dbg_rd_ready, itr_valid, itr_insn. All registers, pointers, count, overflow and counter are 0.
- **Rst mid-operation.** Queue contents are discarded. A read in flight produces no dbg_rd_ready.
- **Read latency: 1 cycle.** A read request at edge N gives dbg_rdata valid and dbg_rd_ready = 1 during cycle N+1. dbg_rd_ready pulses for one cycle only. Writes never raise dbg_rd_ready.
- **STATUS/COUNT reads.** They return the pre-edge state of the request cycle.
- **Push latency: 1 cycle.** A write to ITR_ADDR at edge N into an empty queue gives itr_valid = 1 in cycle N+1.
- **Pop latency.** A pop at edge N shows the next head (or itr_valid = 0) in cycle N+1.
- **Back-to-back traffic.** Sustained throughput is one push and one pop per cycle.

## Configuration
- **CORE_DBG_ITR_COUNTER_EN defined:**
  - COUNT_ADDR reads a DATA_WIDTH counter of pops.
  - The counter increments by 1 per pop and wraps from all-ones to 0.
  - Reset clears the counter; flush does not.
- **CORE_DBG_ITR_COUNTER_EN not defined:**
  - No counter logic is built.
  - COUNT_ADDR reads as 0.

## Test plan
- **Register readback.** Write reg[7] = 0xDEADBEEF, then read reg[7] → dbg_rd_ready pulses one cycle later with dbg_rdata = 0xDEADBEEF.
- **Overflow.** ITR_DEPTH = 4, itr_ready = 0, five ITR writes 0x11 to 0x55.
  - STATUS read returns full = 1, overflow = 1, count = 4.
  - itr_insn = 0x11.
  - Then itr_ready = 1 → 0x11, 0x22, 0x33, 0x44 are popped on consecutive cycles, then itr_valid = 0.
- **Push with pop when full.** Queue full, itr_ready = 1, ITR write 0x99 in the same cycle → count stays 4, overflow stays 0, 0x99 is the last entry popped.
- **Flush and clear.** Three entries queued, overflow set; write STATUS = 0xC → next cycle itr_valid = 0, and a STATUS read returns 0x1 (empty only).
- **Counter.** With the macro defined, 6 pops then a COUNT read → 6. Without the macro, the same read → 0.
- **Reset mid-operation.** Assert rst with two entries queued and a read in flight → next cycle itr_valid = 0, dbg_rd_ready = 0, and reg[ITR_ADDR] reads 0.
